// File: rtl/ms_pkg.sv
// Shared definitions for the multicycle RV32I control path: states, opcodes,
// ALU/extender select codes and the registered control-word layout.
package ms_pkg;

   localparam int ST_W = 4;

   typedef enum logic [ST_W-1:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_JAL      = 4'd9,
      S_BRANCH   = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BR  = 7'b1100011;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLT = 3'b101
   } alu_ctl_t;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } imm_src_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_t;

   typedef struct packed {
      logic       pc_update;
      logic       branch;
      logic       adr_src;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
   } ctl_t;

   function automatic logic [1:0] imm_src_of(input logic [6:0] op);
      case (op)
         OP_SW:   return IMM_S;
         OP_BR:   return IMM_B;
         OP_JAL:  return IMM_J;
         default: return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/ms_alu_decoder.sv
// Combinational ALU control decode from the FSM's aluOp and instruction fields.
module ms_alu_decoder
   import ms_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // funct7b5 only selects sub for register-register ops; addi ignores it
               3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b100:  alu_control = ALU_XOR;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/ms_controller.sv
// Main control FSM of the multicycle RV32I core: sequences memory, ALU,
// register file and extender over 3-5 cycles per instruction.
module ms_controller
   import ms_pkg::*;
#(
   parameter bit BNE_EN  = 1'b1,
   parameter int STATE_W = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic       pcWrite,
   output logic       adrSrc,
   output logic       memWrite,
   output logic       irWrite,
   output logic [1:0] resultSrc,
   output logic [1:0] aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [1:0] immSrc,
   output logic       regWrite,
   output logic [2:0] aluControl,
   output logic       illegal
);

   localparam logic [STATE_W-1:0] FETCH    = STATE_W'(S_FETCH);
   localparam logic [STATE_W-1:0] DECODE   = STATE_W'(S_DECODE);
   localparam logic [STATE_W-1:0] MEMADR   = STATE_W'(S_MEMADR);
   localparam logic [STATE_W-1:0] MEMREAD  = STATE_W'(S_MEMREAD);
   localparam logic [STATE_W-1:0] MEMWB    = STATE_W'(S_MEMWB);
   localparam logic [STATE_W-1:0] MEMWRITE = STATE_W'(S_MEMWRITE);
   localparam logic [STATE_W-1:0] EXECUTER = STATE_W'(S_EXECUTER);
   localparam logic [STATE_W-1:0] EXECUTEI = STATE_W'(S_EXECUTEI);
   localparam logic [STATE_W-1:0] ALUWB    = STATE_W'(S_ALUWB);
   localparam logic [STATE_W-1:0] JAL      = STATE_W'(S_JAL);
   localparam logic [STATE_W-1:0] BRANCH   = STATE_W'(S_BRANCH);

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] state_nxt;
   ctl_t               ctl;
   logic               op_ok;

   // Control word for a state; undefined encodings get all zeros
   function automatic ctl_t ctl_of(input logic [STATE_W-1:0] s);
      ctl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.ir_write   = 1'b1;
            c.pc_update  = 1'b1;
            c.alu_src_b  = 2'b10;
            c.result_src = 2'b10;
         end
         DECODE: begin
            c.alu_src_a = 2'b01;
            c.alu_src_b = 2'b01;
         end
         MEMADR: begin
            c.alu_src_a = 2'b10;
            c.alu_src_b = 2'b01;
         end
         MEMREAD:  c.adr_src = 1'b1;
         MEMWRITE: begin
            c.adr_src   = 1'b1;
            c.mem_write = 1'b1;
         end
         MEMWB: begin
            c.result_src = 2'b01;
            c.reg_write  = 1'b1;
         end
         EXECUTER: begin
            c.alu_src_a = 2'b10;
            c.alu_op    = ALUOP_FUNCT;
         end
         EXECUTEI: begin
            c.alu_src_a = 2'b10;
            c.alu_src_b = 2'b01;
            c.alu_op    = ALUOP_FUNCT;
         end
         ALUWB: c.reg_write = 1'b1;
         JAL: begin
            c.alu_src_a = 2'b01;
            c.alu_src_b = 2'b10;
            c.pc_update = 1'b1;
         end
         BRANCH: begin
            c.alu_src_a = 2'b10;
            c.alu_op    = ALUOP_SUB;
            c.branch    = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   assign op_ok = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                  (op == OP_I)  || (op == OP_JAL) || (op == OP_BR);

   always_comb begin
      state_nxt = FETCH;
      case (state)
         FETCH: state_nxt = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: state_nxt = MEMADR;
               OP_R:         state_nxt = EXECUTER;
               OP_I:         state_nxt = EXECUTEI;
               OP_JAL:       state_nxt = JAL;
               OP_BR:        state_nxt = BRANCH;
               default:      state_nxt = FETCH;
            endcase
         end
         MEMADR:             state_nxt = op[5] ? MEMWRITE : MEMREAD;
         MEMREAD:            state_nxt = MEMWB;
         EXECUTER, EXECUTEI: state_nxt = ALUWB;
         JAL:                state_nxt = ALUWB;
         default:            state_nxt = FETCH;
      endcase
   end

   // Control word is registered alongside the state it belongs to
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCH;
         ctl   <= ctl_of(FETCH);
      end else begin
         state <= state_nxt;
         ctl   <= ctl_of(state_nxt);
      end
   end

   // Write enables are gated by reset; the ctl register holds FETCH values meanwhile
   assign pcWrite   = ~reset & (ctl.pc_update |
                                (ctl.branch & (zero ^ (BNE_EN & funct3[0]))));
   assign irWrite   = ~reset & ctl.ir_write;
   assign memWrite  = ~reset & ctl.mem_write;
   assign regWrite  = ~reset & ctl.reg_write;
   assign adrSrc    = ctl.adr_src;
   assign resultSrc = ctl.result_src;
   assign aluSrcA   = ctl.alu_src_a;
   assign aluSrcB   = ctl.alu_src_b;
   assign immSrc    = imm_src_of(op);
   assign illegal   = (state == DECODE) & ~op_ok;

   ms_alu_decoder u_alu_dec (
      .alu_op      (ctl.alu_op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .op5         (op[5]),
      .alu_control (aluControl)
   );

endmodule
